// File: rtl/rv_pkg.sv
// Shared RV32I definitions: instruction-class codes, opcodes, fetch FSM states, fetch FIFO entry.
package rv_pkg;

  localparam logic [3:0] CLS_LOAD    = 4'd0;
  localparam logic [3:0] CLS_IMM     = 4'd1;
  localparam logic [3:0] CLS_STORE   = 4'd2;
  localparam logic [3:0] CLS_REG     = 4'd3;
  localparam logic [3:0] CLS_LUI     = 4'd4;
  localparam logic [3:0] CLS_AUIPC   = 4'd5;
  localparam logic [3:0] CLS_BRANCH  = 4'd6;
  localparam logic [3:0] CLS_JALR    = 4'd7;
  localparam logic [3:0] CLS_JAL     = 4'd8;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  cls;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: PC input handshake, instruction-memory port, decode-side output.
interface instr_fetch_if;
  logic [31:0] pc_in;
  logic        pc_in_valid;
  logic        pc_in_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [3:0]  if_type;

  modport master (
    input  pc_in, pc_in_valid, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output pc_in_ready, imem_req, imem_addr, if_valid, if_pc, if_instr, if_type
  );

  modport slave (
    output pc_in, pc_in_valid, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  pc_in_ready, imem_req, imem_addr, if_valid, if_pc, if_instr, if_type
  );
endinterface

// File: rtl/instr_classify.sv
// Combinational RV32I opcode to instruction-class decoder; zero latency.
module instr_classify
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] cls
);

  // Compressed encodings (opcode[1:0] != 2'b11) never match and fall to illegal.
  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_LOAD:   cls = CLS_LOAD;
      OP_IMM:    cls = CLS_IMM;
      OP_STORE:  cls = CLS_STORE;
      OP_REG:    cls = CLS_REG;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JALR:   cls = CLS_JALR;
      OP_JAL:    cls = CLS_JAL;
      default:   cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch into a DEPTH-entry FIFO; 3 cycles accept-to-valid best case.
// A FIFO slot is reserved at accept, so pc_in_ready drops while the FIFO is full or a fetch is in flight.
module instr_fetch
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  instr_fetch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e  state;
  logic [31:0]   addr;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  head;
  logic [3:0]    rd_cls;
  logic          accept, push, pop, not_empty;

  instr_classify u_classify (
    .opcode (bus.imem_rdata[6:0]),
    .cls    (rd_cls)
  );

  assign not_empty       = (count != '0);
  assign bus.pc_in_ready = rst_n && (state == FS_IDLE) && (count < FULL) && !bus.flush;
  assign accept          = bus.pc_in_valid && bus.pc_in_ready;
  assign push            = (state == FS_WAIT) && bus.imem_rvalid && !bus.flush;
  assign pop             = not_empty && bus.if_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FS_IDLE;
      addr   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        FS_IDLE: begin
          if (accept) begin
            addr  <= bus.pc_in & ~32'h3;
            state <= FS_REQ;
          end
        end
        FS_REQ: begin
          // A grant in the flush cycle still owes us a response, which must be drained.
          if (bus.imem_gnt)   state <= bus.flush ? FS_DRAIN : FS_WAIT;
          else if (bus.flush) state <= FS_IDLE;
        end
        FS_WAIT: begin
          if (bus.imem_rvalid) state <= FS_IDLE;
          else if (bus.flush)  state <= FS_DRAIN;
        end
        FS_DRAIN: begin
          if (bus.imem_rvalid) state <= FS_IDLE;
        end
        default: state <= FS_IDLE;
      endcase

      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= '{pc: addr, instr: bus.imem_rdata, cls: rd_cls};
  end

  assign head          = mem[rd_ptr];
  assign bus.imem_req  = (state == FS_REQ);
  assign bus.imem_addr = addr;
  assign bus.if_valid  = not_empty;
  assign bus.if_pc     = not_empty ? head.pc    : '0;
  assign bus.if_instr  = not_empty ? head.instr : '0;
  assign bus.if_type   = not_empty ? head.cls   : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with hand-computed expectations.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  instr_fetch_if bus ();

  instr_fetch #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept pc, grant after gd stall cycles, return instr on the following cycle.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input int gd);
    int k;
    bus.pc_in       = pc;
    bus.pc_in_valid = 1'b1;
    k = 0;
    #1;
    while (!bus.pc_in_ready && k < 20) begin
      tick();
      k++;
    end
    chk("pc_in_ready_wait", {31'd0, bus.pc_in_ready}, 32'd1);
    tick();
    bus.pc_in_valid = 1'b0;
    for (int d = 0; d <= gd; d++) begin
      chk("req_held", {31'd0, bus.imem_req}, 32'd1);
      chk("addr_held", bus.imem_addr, pc & ~32'h3);
      bus.imem_gnt = (d == gd);
      tick();
    end
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = instr;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
  endtask

  task automatic pop();
    bus.if_ready = 1'b1;
    tick();
    bus.if_ready = 1'b0;
    #1;
  endtask

  logic [31:0] cls_instr [3] = '{32'h00008067, 32'hFFFFFFFF, 32'h00000001};
  logic [3:0]  cls_exp   [3] = '{4'd7, 4'd15, 4'd15};

  initial begin
    rst_n = 1'b0;
    bus.pc_in = '0; bus.pc_in_valid = 1'b0; bus.flush = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.if_ready = 1'b0;
    tick(); tick();
    bus.pc_in_valid = 1'b1;
    #1;
    chk("rst_ready", {31'd0, bus.pc_in_ready}, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_pc", bus.if_pc, 32'd0);
    chk("rst_instr", bus.if_instr, 32'd0);
    chk("rst_type", {28'd0, bus.if_type}, 32'd0);
    bus.pc_in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Best-case latency: accept N, req N+1, rvalid N+2, if_valid N+3.
    bus.pc_in = 32'h100; bus.pc_in_valid = 1'b1;
    #1;
    chk("t1_ready", {31'd0, bus.pc_in_ready}, 32'd1);
    tick();
    bus.pc_in_valid = 1'b0;
    chk("t1_req", {31'd0, bus.imem_req}, 32'd1);
    chk("t1_addr", bus.imem_addr, 32'h100);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    chk("t1_valid_early", {31'd0, bus.if_valid}, 32'd0);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00500093;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("t1_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("t1_pc", bus.if_pc, 32'h100);
    chk("t1_instr", bus.if_instr, 32'h00500093);
    chk("t1_type", {28'd0, bus.if_type}, 32'd1);
    pop();
    chk("t1_empty", {31'd0, bus.if_valid}, 32'd0);

    // Full FIFO holds off a third PC; drain order 0x0, 0x4, 0x8.
    fetch(32'h0, 32'h00002003, 0);
    fetch(32'h4, 32'h00002023, 0);
    bus.pc_in = 32'h8; bus.pc_in_valid = 1'b1;
    #1;
    chk("t2_full_ready", {31'd0, bus.pc_in_ready}, 32'd0);
    tick(); tick();
    chk("t2_held_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t2_head0_pc", bus.if_pc, 32'h0);
    chk("t2_head0_type", {28'd0, bus.if_type}, 32'd0);
    pop();
    fetch(32'h8, 32'h00000033, 0);
    chk("t2_head1_pc", bus.if_pc, 32'h4);
    chk("t2_head1_type", {28'd0, bus.if_type}, 32'd2);
    pop();
    chk("t2_head2_pc", bus.if_pc, 32'h8);
    chk("t2_head2_type", {28'd0, bus.if_type}, 32'd3);
    pop();
    chk("t2_empty", {31'd0, bus.if_valid}, 32'd0);

    // Delayed grant; unaligned PC fetched at the word address.
    fetch(32'h203, 32'h00000063, 3);
    chk("t3_pc", bus.if_pc, 32'h200);
    chk("t3_type", {28'd0, bus.if_type}, 32'd6);
    pop();

    // Flush while waiting for data: response two cycles later is dropped.
    bus.pc_in = 32'h300; bus.pc_in_valid = 1'b1;
    tick();
    bus.pc_in_valid = 1'b0; bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("t4_drain_ready", {31'd0, bus.pc_in_ready}, 32'd0);
    chk("t4_drain_req", {31'd0, bus.imem_req}, 32'd0);
    tick();
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00100093;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    chk("t4_no_push", {31'd0, bus.if_valid}, 32'd0);
    chk("t4_idle_ready", {31'd0, bus.pc_in_ready}, 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("t4_flush_ready", {31'd0, bus.pc_in_ready}, 32'd0);
    bus.flush = 1'b0;
    fetch(32'h40, 32'h0000006F, 0);
    chk("t4_next_pc", bus.if_pc, 32'h40);
    chk("t4_next_type", {28'd0, bus.if_type}, 32'd8);
    pop();

    // Flush coinciding with rvalid while one entry is buffered.
    fetch(32'h80, 32'h000012B7, 0);
    chk("t5_buffered_type", {28'd0, bus.if_type}, 32'd4);
    bus.pc_in = 32'h84; bus.pc_in_valid = 1'b1;
    tick();
    bus.pc_in_valid = 1'b0; bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00000013;
    bus.flush = 1'b1;
    tick();
    bus.imem_rvalid = 1'b0; bus.flush = 1'b0;
    #1;
    chk("t5_empty", {31'd0, bus.if_valid}, 32'd0);
    chk("t5_pc_zero", bus.if_pc, 32'd0);
    chk("t5_idle_ready", {31'd0, bus.pc_in_ready}, 32'd1);
    chk("t5_req", {31'd0, bus.imem_req}, 32'd0);

    // Remaining classifier vectors.
    for (int i = 0; i < 3; i++) begin
      fetch(32'h1000 + 32'(i * 4), cls_instr[i], 0);
      chk("t6_class", {28'd0, bus.if_type}, {28'd0, cls_exp[i]});
      pop();
    end

    // Reset during a request; a stray rvalid afterwards is ignored.
    bus.pc_in = 32'h500; bus.pc_in_valid = 1'b1;
    tick();
    bus.pc_in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("t7_rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t7_rst_addr", bus.imem_addr, 32'd0);
    rst_n = 1'b1;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00000013;
    tick();
    bus.imem_rvalid = 1'b0;
    #1;
    chk("t7_stray", {31'd0, bus.if_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
